// File: rtl/ucie_ctl_sb_tx_arbiter.sv
// Credit-based round-robin arbiter sharing one sideband TX message path between NREQ requesters.
// Optional build macro UCIE_CTL_SB_ARB_PRIORITY_EN gives requester 0 fixed top priority.
module ucie_ctl_sb_tx_arbiter #(
  parameter int unsigned NC      = 32,
  parameter int unsigned NREQ    = 3,
  parameter int unsigned CREDITS = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_enable,
  input  logic [NREQ-1:0]          i_req_valid,
  input  logic [NREQ-1:0][NC-1:0]  i_req_data,
  output logic [NREQ-1:0]          o_req_grant,
  output logic                     o_sb_valid,
  output logic [NC-1:0]            o_sb_data,
  input  logic                     i_sb_crd_return,
  output logic [3:0]               o_credit_cnt,
  output logic                     o_busy,
  output logic                     o_crd_overflow
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     crd_q, crd_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              sb_valid_q, sb_valid_d;
  logic [NC-1:0]     sb_data_q, sb_data_d;
  logic              ovf_q, ovf_d;

  logic [NREQ-1:0]   rr_req;
  logic [2*NREQ-1:0] req2;
  logic              win_found;
  logic [PW-1:0]     win_idx;
  logic              issue;

  // Winner search: first requester above the pointer in a doubled request vector (handles wrap).
  always_comb begin
    rr_req    = i_req_valid;
`ifdef UCIE_CTL_SB_ARB_PRIORITY_EN
    rr_req[0] = 1'b0;
`endif
    req2      = {rr_req, rr_req};
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < 2*NREQ; k++) begin
      if (!win_found && (k > 32'(ptr_q)) && req2[k]) begin
        win_found = 1'b1;
        win_idx   = PW'((k >= NREQ) ? (k - NREQ) : k);
      end
    end
`ifdef UCIE_CTL_SB_ARB_PRIORITY_EN
    if (i_req_valid[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`endif
  end

  // Next-state, issue and credit bookkeeping.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    crd_d      = crd_q;
    grant_d    = '0;
    sb_valid_d = 1'b0;
    sb_data_d  = sb_data_q;
    ovf_d      = ovf_q;
    issue      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_enable && (crd_q != '0) && win_found) begin
          issue            = 1'b1;
          state_d          = SEND;
          grant_d[win_idx] = 1'b1;
          sb_valid_d       = 1'b1;
          sb_data_d        = i_req_data[win_idx];
`ifdef UCIE_CTL_SB_ARB_PRIORITY_EN
          if (win_idx != '0) ptr_d = win_idx;
`else
          ptr_d            = win_idx;
`endif
        end
      end
      SEND:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (issue && !i_sb_crd_return) begin
      crd_d = crd_q - CW'(1);
    end else if (!issue && i_sb_crd_return) begin
      if (crd_q == CW'(CREDITS)) ovf_d = 1'b1;
      else                       crd_d = crd_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= PW'(NREQ - 1);
      crd_q      <= CW'(CREDITS);
      grant_q    <= '0;
      sb_valid_q <= 1'b0;
      sb_data_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      crd_q      <= crd_d;
      grant_q    <= grant_d;
      sb_valid_q <= sb_valid_d;
      sb_data_q  <= sb_data_d;
      ovf_q      <= ovf_d;
    end
  end

  assign o_req_grant    = grant_q;
  assign o_sb_valid     = sb_valid_q;
  assign o_sb_data      = sb_data_q;
  assign o_credit_cnt   = crd_q;
  assign o_busy         = (state_q == SEND);
  assign o_crd_overflow = ovf_q;

endmodule
